// File: rtl/mem_stack_unit.sv
// Memory-side responder for the accumulator CPU sequencer: RAM, stack pointer, address and write-data muxing.
// Optional stack overflow/underflow guard enabled by defining MEM_STACK_GUARD_EN.
module mem_stack_unit #(
  parameter int                ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] SP_RESET    = 8'hFF,
  parameter logic [ADDR_W-1:0] STACK_LIMIT = 8'hC0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              FETCH,
  input  logic              STORE_MEM,
  input  logic              SP_ADDR,
  input  logic              LOAD_SP,
  input  logic              SP_INC,
  input  logic              SP_DEC,
  input  logic              MEM_IN_SRC,
  input  logic [ADDR_W-1:0] PC_in,
  input  logic [ADDR_W-1:0] IRL_in,
  input  logic [ADDR_W-1:0] AC_in,
  input  logic              PROG_WE,
  input  logic [ADDR_W-1:0] PROG_ADDR,
  input  logic [ADDR_W-1:0] PROG_DATA,
  output logic [ADDR_W-1:0] RAM_out,
  output logic [ADDR_W-1:0] SP,
  output logic              STK_OVF,
  output logic              STK_UNF
);

  localparam int                DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ONE   = 1;

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] sp_r, sp_next;
  logic [ADDR_W-1:0] addr, wdata;
  logic              dec_go, inc_go, sp_both;
  logic              ovf_hit, unf_hit, we;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    addr    = IRL_in;
    wdata   = MEM_IN_SRC ? PC_in : AC_in;
    sp_both = SP_INC & SP_DEC & ~LOAD_SP;
    dec_go  = SP_DEC & ~SP_INC & ~LOAD_SP;
    inc_go  = SP_INC & ~SP_DEC & ~LOAD_SP;
    ovf_hit = 1'b0;
    unf_hit = 1'b0;
    sp_next = sp_r;

    if (SP_ADDR && SP_DEC) addr = sp_r - ONE;
    else if (SP_ADDR)      addr = sp_r;
    else if (FETCH)        addr = PC_in;

`ifdef MEM_STACK_GUARD_EN
    ovf_hit = dec_go && (sp_r == STACK_LIMIT);
    unf_hit = inc_go && (sp_r == SP_RESET);
`endif

    // Conflicting INC+DEC freezes the stack: no pointer move and no write.
    we = ~RESET & STORE_MEM & ~sp_both & ~ovf_hit;

    if (LOAD_SP)                 sp_next = IRL_in;
    else if (dec_go && !ovf_hit) sp_next = sp_r - ONE;
    else if (inc_go && !unf_hit) sp_next = sp_r + ONE;
  end

  // NOTE: the RAM array has no reset; contents survive RESET and only the loader touches them then.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      if (PROG_WE) mem[PROG_ADDR] <= PROG_DATA;
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  // NOTE: non-blocking assignment makes the read return the pre-write contents on a write cycle.
  always_ff @(posedge CLK) begin
    if (RESET) RAM_out <= '0;
    else       RAM_out <= mem[addr];
  end

  always_ff @(posedge CLK) begin
    if (RESET) sp_r <= SP_RESET;
    else       sp_r <= sp_next;
  end

  assign SP = sp_r;

`ifdef MEM_STACK_GUARD_EN
  logic ovf_r, unf_r;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r | ovf_hit;
      unf_r <= unf_r | unf_hit;
    end
  end

  assign STK_OVF = ovf_r;
  assign STK_UNF = unf_r;
`else
  assign STK_OVF = 1'b0;
  assign STK_UNF = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stack_unit.sv
// Self-checking bench for mem_stack_unit: directed scenarios followed by random strobes against a behavioural model.
module tb_mem_stack_unit;

  logic       CLK = 1'b0;
  logic       RESET, FETCH, STORE_MEM, SP_ADDR, LOAD_SP, SP_INC, SP_DEC, MEM_IN_SRC, PROG_WE;
  logic [7:0] PC_in, IRL_in, AC_in, PROG_ADDR, PROG_DATA;
  logic [7:0] RAM_out, SP;
  logic       STK_OVF, STK_UNF;

  mem_stack_unit dut (
    .CLK(CLK), .RESET(RESET), .FETCH(FETCH), .STORE_MEM(STORE_MEM), .SP_ADDR(SP_ADDR),
    .LOAD_SP(LOAD_SP), .SP_INC(SP_INC), .SP_DEC(SP_DEC), .MEM_IN_SRC(MEM_IN_SRC),
    .PC_in(PC_in), .IRL_in(IRL_in), .AC_in(AC_in), .PROG_WE(PROG_WE),
    .PROG_ADDR(PROG_ADDR), .PROG_DATA(PROG_DATA), .RAM_out(RAM_out), .SP(SP),
    .STK_OVF(STK_OVF), .STK_UNF(STK_UNF)
  );

  always #5 CLK = ~CLK;

  // Reference state.
  logic [7:0] m_mem [256];
  logic [7:0] m_ram, m_sp;
  logic       m_ovf, m_unf;
  int         n_checks = 0, n_pass = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
  endtask

  task automatic idle();
    FETCH = 0; STORE_MEM = 0; SP_ADDR = 0; LOAD_SP = 0; SP_INC = 0; SP_DEC = 0;
    MEM_IN_SRC = 0; PROG_WE = 0;
  endtask

  // Apply the rules for one clock edge to the model, clock the DUT, then compare.
  task automatic tick(input string tag);
    logic [7:0] a;
    logic       freeze, dec, inc, block_dec, block_inc;
    if (RESET) begin
      if (PROG_WE) m_mem[PROG_ADDR] = PROG_DATA;
      m_ram = 8'h00; m_sp = 8'hFF; m_ovf = 0; m_unf = 0;
    end else begin
      if (SP_ADDR)    a = SP_DEC ? m_sp - 8'd1 : m_sp;
      else if (FETCH) a = PC_in;
      else            a = IRL_in;
      m_ram     = m_mem[a];
      freeze    = SP_INC && SP_DEC && !LOAD_SP;
      dec       = SP_DEC && !SP_INC && !LOAD_SP;
      inc       = SP_INC && !SP_DEC && !LOAD_SP;
      block_dec = 0;
      block_inc = 0;
`ifdef MEM_STACK_GUARD_EN
      if (dec && m_sp == 8'hC0) begin block_dec = 1; m_ovf = 1; end
      if (inc && m_sp == 8'hFF) begin block_inc = 1; m_unf = 1; end
`endif
      if (STORE_MEM && !freeze && !block_dec) m_mem[a] = MEM_IN_SRC ? PC_in : AC_in;
      if (LOAD_SP)                 m_sp = IRL_in;
      else if (dec && !block_dec)  m_sp = m_sp - 8'd1;
      else if (inc && !block_inc)  m_sp = m_sp + 8'd1;
    end
    @(posedge CLK);
    #1;
    check({tag, ".ram"}, RAM_out, m_ram);
    check({tag, ".sp"},  SP, m_sp);
    check({tag, ".ovf"}, {7'd0, STK_OVF}, {7'd0, m_ovf});
    check({tag, ".unf"}, {7'd0, STK_UNF}, {7'd0, m_unf});
    @(negedge CLK);
  endtask

  task automatic read_irl(input logic [7:0] a, input string tag);
    idle(); IRL_in = a; tick(tag);
  endtask

  task automatic push(input logic src, input logic [7:0] d, input string tag);
    idle(); SP_ADDR = 1; SP_DEC = 1; STORE_MEM = 1; MEM_IN_SRC = src;
    if (src) PC_in = d; else AC_in = d;
    tick(tag);
  endtask

  task automatic pop(input string tag);
    idle(); SP_ADDR = 1; tick({tag, "1"});
    SP_INC = 1; tick({tag, "2"});
  endtask

  initial begin
    RESET = 1; PC_in = 0; IRL_in = 0; AC_in = 0; PROG_ADDR = 0; PROG_DATA = 0;
    idle();
    @(negedge CLK);

    // Loader fills the whole RAM so every later read has a defined reference value.
    for (int i = 0; i < 256; i++) begin
      PROG_WE = 1; PROG_ADDR = 8'(i); PROG_DATA = 8'($urandom);
      if (i == 0) PROG_DATA = 8'h02;
      if (i == 1) PROG_DATA = 8'h5A;
      tick("load");
    end
    idle();
    check("reset.sp", SP, 8'hFF);
    check("reset.ram", RAM_out, 8'h00);

    RESET = 0;
    FETCH = 1; PC_in = 8'h00; tick("fetch0");
    check("fetch0.val", RAM_out, 8'h02);
    PC_in = 8'h01; tick("fetch1");
    check("fetch1.val", RAM_out, 8'h5A);

    idle(); STORE_MEM = 1; IRL_in = 8'h40; AC_in = 8'h3C; tick("store_rbw");
    read_irl(8'h40, "store_rd");
    check("store.val", RAM_out, 8'h3C);

    idle(); LOAD_SP = 1; IRL_in = 8'hF0; tick("ldsp");
    push(0, 8'h11, "push");
    check("push.sp", SP, 8'hEF);
    pop("pop");
    check("pop.val", RAM_out, 8'h11);
    check("pop.sp", SP, 8'hF0);

    push(1, 8'h24, "jsr");
    check("jsr.sp", SP, 8'hEF);
    pop("rts");
    check("rts.val", RAM_out, 8'h24);
    check("rts.sp", SP, 8'hF0);

    // Stack limit and empty-stack boundaries.
    idle(); LOAD_SP = 1; IRL_in = 8'hC0; tick("ldlim");
    push(0, 8'h77, "push_lim");
`ifdef MEM_STACK_GUARD_EN
    check("lim.sp", SP, 8'hC0);
    check("lim.ovf", {7'd0, STK_OVF}, 8'h01);
`else
    check("lim.sp", SP, 8'hBF);
`endif
    read_irl(8'hBF, "lim_rd");
    idle(); RESET = 1; tick("rst1");
    RESET = 0; SP_INC = 1; tick("inc_empty");
`ifdef MEM_STACK_GUARD_EN
    check("empty.sp", SP, 8'hFF);
    check("empty.unf", {7'd0, STK_UNF}, 8'h01);
`else
    check("empty.sp", SP, 8'h00);
`endif

    idle(); LOAD_SP = 1; IRL_in = 8'h80; tick("ld80");
    idle(); SP_ADDR = 1; SP_INC = 1; SP_DEC = 1; STORE_MEM = 1; AC_in = 8'h99; tick("incdec");
    check("incdec.sp", SP, 8'h80);
    read_irl(8'h7F, "incdec_rd7f");
    read_irl(8'h80, "incdec_rd80");

    idle(); LOAD_SP = 1; IRL_in = 8'hF0; tick("ldf0");
    RESET = 1; LOAD_SP = 0; SP_ADDR = 1; SP_DEC = 1; STORE_MEM = 1; AC_in = 8'hA5; tick("rst_push");
    check("rst_push.sp", SP, 8'hFF);
    RESET = 0;
    read_irl(8'hEF, "rst_push_rd");
    read_irl(8'hFE, "rst_push_rdfe");

    // Random strobe mix, with occasional reset/loader cycles.
    for (int i = 0; i < 3000; i++) begin
      RESET      = ($urandom_range(0, 63) == 0);
      PROG_WE    = $urandom_range(0, 1) == 1;
      PROG_ADDR  = 8'($urandom); PROG_DATA = 8'($urandom);
      FETCH      = $urandom_range(0, 2) == 0;
      STORE_MEM  = $urandom_range(0, 2) == 0;
      SP_ADDR    = $urandom_range(0, 1) == 1;
      LOAD_SP    = $urandom_range(0, 15) == 0;
      SP_INC     = $urandom_range(0, 2) == 0;
      SP_DEC     = $urandom_range(0, 2) == 0;
      MEM_IN_SRC = $urandom_range(0, 1) == 1;
      PC_in      = 8'($urandom); AC_in = 8'($urandom);
      IRL_in     = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(8'hBE, 8'hC2)) : 8'($urandom);
      tick("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
